// File: rtl/gen_lut_ram_loader_pkg.sv
//==============================================================================
// Module      : gen_lut_ram_loader_pkg
// Description : Shared widths and FSM state encoding for the LUT RAM loader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package gen_lut_ram_loader_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_ROM_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

`default_nettype wire

// File: rtl/gen_lut_ram.sv
//==============================================================================
// Module      : gen_lut_ram
// Description : Simple dual-port LUT RAM, synchronous write, registered
//               read-first lookup port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gen_lut_ram
    import gen_lut_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ROM_WIDTH  = DEF_ROM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ROM_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ROM_WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ROM_WIDTH-1:0] mem [0:DEPTH-1];

    // Contents deliberately have no reset so a table survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/gen_lut_ram_loader.sv
//==============================================================================
// Module      : gen_lut_ram_loader
// Description : Streams valid/ready words into consecutive LUT RAM addresses;
//               independent registered lookup port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gen_lut_ram_loader
    import gen_lut_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ROM_WIDTH  = DEF_ROM_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ROM_WIDTH-1:0]  wr_data_i,
    input  logic                  wr_valid_i,
    input  logic                  wr_last_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [ROM_WIDTH-1:0]  rd_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    load_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic                  w_accept;
    logic                  w_full;

    assign w_accept = wr_valid_i & wr_ready_o;
    assign w_full   = (r_wptr == LAST_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            wr_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            count_o    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_state    <= ST_LOAD;
                        r_wptr     <= '0;
                        count_o    <= '0;
                        err_o      <= 1'b0;
                        wr_ready_o <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        count_o <= count_o + CNT_ONE;
                        // The pointer is held at the top address rather than wrapping.
                        if (wr_last_i || w_full) begin
                            r_state    <= ST_DONE;
                            wr_ready_o <= 1'b0;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            err_o      <= ~wr_last_i;
                        end else begin
                            r_wptr <= r_wptr + PTR_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    wr_ready_o <= 1'b0;
                    busy_o     <= 1'b0;
                    done_o     <= 1'b0;
                end
            endcase
        end
    end

    gen_lut_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ROM_WIDTH  (ROM_WIDTH)
    ) u_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (w_accept),
        .wr_addr (r_wptr),
        .wr_data (wr_data_i),
        .rd_addr (rd_addr_i),
        .rd_data (rd_data_o)
    );

endmodule

`default_nettype wire
